// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine.
// On a miss it streams the 16-byte block containing the missing address out of
// a pipelined main memory (one request per cycle), writes every returned word
// into the cache data array as it arrives, writes the tag together with the
// last word, then holds the pipeline one extra cycle so the cache can
// re-evaluate the hit before the CPU is released.
module cache_fill_fsm #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [DATA_W-1:0] memory_data,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic              write_tag_array,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_data
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    localparam logic [3:0] NUM_WORDS = 4'(BLOCK_WORDS);
    localparam logic [3:0] LAST_WORD = 4'(BLOCK_WORDS - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-5:0] base_hi;
    logic [ADDR_W-5:0] base_hi_next;
    logic [3:0]        req_cnt;
    logic [3:0]        req_cnt_next;
    logic [3:0]        rsp_cnt;
    logic [3:0]        rsp_cnt_next;

    // The byte/word offset of the missing address never matters: the whole
    // block is fetched starting from word 0.
    logic              unused_offset;
    assign unused_offset = ^miss_address[3:0];

    // State, block base and the two independent request/response counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            base_hi <= '0;
            req_cnt <= '0;
            rsp_cnt <= '0;
        end else begin
            state   <= state_next;
            base_hi <= base_hi_next;
            req_cnt <= req_cnt_next;
            rsp_cnt <= rsp_cnt_next;
        end
    end

    // Next-state logic and strobes. Only the word-offset bits of an address
    // are ever computed from a counter, so the upper block bits can never be
    // disturbed by a carry. Everything is forced quiet while rst is high so a
    // fill aborted by reset cannot leak one more write.
    always_comb begin
        state_next       = state;
        base_hi_next     = base_hi;
        req_cnt_next     = req_cnt;
        rsp_cnt_next     = rsp_cnt;
        fsm_busy         = 1'b0;
        mem_en           = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        cache_addr       = '0;
        cache_data       = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base_hi_next = miss_address[ADDR_W-1:4];
                        req_cnt_next = '0;
                        rsp_cnt_next = '0;
                        state_next   = FILL;
                    end
                end
                FILL: begin
                    fsm_busy = 1'b1;
                    if (req_cnt < NUM_WORDS) begin
                        mem_en         = 1'b1;
                        memory_address = {base_hi, req_cnt[2:0], 1'b0};
                        req_cnt_next   = req_cnt + 4'd1;
                    end
                    if (memory_data_valid) begin
                        write_data_array = 1'b1;
                        cache_addr       = {base_hi, rsp_cnt[2:0], 1'b0};
                        cache_data       = memory_data;
                        rsp_cnt_next     = rsp_cnt + 4'd1;
                        if (rsp_cnt == LAST_WORD) begin
                            write_tag_array = 1'b1;
                            state_next      = DONE;
                        end
                    end
                end
                DONE: begin
                    fsm_busy   = 1'b1;
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomized scoreboard bench for cache_fill_fsm.
// A pipelined memory model answers requests in order after a programmable
// latency, optionally with random gaps. Each issued miss pushes the block's
// expected requests, writes and busy length into queues; an independent
// monitor pops them whenever the DUT strobes.
module tb_cache_fill_fsm;

    typedef struct {
        logic [15:0] addr;
        int          cyc;
    } req_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
        bit          tag;
    } wr_t;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } pend_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data = 16'h0;
    logic        memory_data_valid = 1'b0;
    logic        fsm_busy;
    logic        mem_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] cache_addr;
    logic [15:0] cache_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 4;
    bit gap_mode = 1'b0;
    int busy_run = 0;

    req_t  exp_req[$];
    wr_t   exp_wr[$];
    int    exp_busy[$];
    pend_t pend[$];
    int    spur_cyc[$];

    cache_fill_fsm dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .memory_data      (memory_data),
        .memory_data_valid(memory_data_valid),
        .fsm_busy         (fsm_busy),
        .mem_en           (mem_en),
        .memory_address   (memory_address),
        .write_data_array (write_data_array),
        .write_tag_array  (write_tag_array),
        .cache_addr       (cache_addr),
        .cache_data       (cache_data)
    );

    // Free-running clock and cycle index (interval k follows posedge k).
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Pipelined memory: accept requests seen this cycle, answer the oldest
    // one once its latency has elapsed, and inject stray valid pulses on
    // request from the stimulus.
    always @(negedge clk) begin
        pend_t p;
        if (rst) begin
            pend.delete();
            memory_data_valid = 1'b0;
        end else begin
            if (mem_en === 1'b1) begin
                p.addr = memory_address;
                p.due  = cyc + lat;
                pend.push_back(p);
            end
            memory_data_valid = 1'b0;
            memory_data       = 16'($urandom);
            if (pend.size() > 0 && pend[0].due <= cyc &&
                (!gap_mode || $urandom_range(0, 1) == 1)) begin
                p                 = pend.pop_front();
                memory_data       = p.addr ^ 16'hA5A5;
                memory_data_valid = 1'b1;
            end
            foreach (spur_cyc[i]) begin
                if (spur_cyc[i] == cyc && !memory_data_valid) begin
                    memory_data_valid = 1'b1;
                    memory_data       = 16'($urandom);
                end
            end
        end
    end

    // Monitor: every strobe consumes the next expected item.
    always @(negedge clk) begin
        req_t r;
        wr_t  w;
        int   b;
        #2;
        if (mem_en === 1'b1) begin
            checks++;
            if (exp_req.size() == 0) begin
                errors++;
                $display("[TB] FAIL req_unexpected: got addr %h, expected no request", memory_address);
            end else begin
                r = exp_req.pop_front();
                if (memory_address !== r.addr || (r.cyc >= 0 && r.cyc != cyc)) begin
                    errors++;
                    $display("[TB] FAIL req: got addr %h at cycle %0d, expected %h at cycle %0d",
                             memory_address, cyc, r.addr, r.cyc);
                end
            end
        end
        if (write_data_array === 1'b1) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("[TB] FAIL write_unexpected: got addr %h data %h, expected no write",
                         cache_addr, cache_data);
            end else begin
                w = exp_wr.pop_front();
                if (cache_addr !== w.addr || cache_data !== w.data ||
                    write_tag_array !== w.tag || (w.cyc >= 0 && w.cyc != cyc)) begin
                    errors++;
                    $display("[TB] FAIL write: got addr %h data %h tag %b cycle %0d, expected %h %h %b %0d",
                             cache_addr, cache_data, write_tag_array, cyc, w.addr, w.data, w.tag, w.cyc);
                end
            end
        end else if (write_tag_array !== 1'b0 && fsm_busy !== 1'bx) begin
            checks++;
            errors++;
            $display("[TB] FAIL tag_alone: got write_tag_array %b, expected 0 without data write",
                     write_tag_array);
        end
        if (fsm_busy === 1'b1) begin
            busy_run++;
        end else if (busy_run > 0) begin
            checks++;
            if (exp_busy.size() == 0) begin
                errors++;
                $display("[TB] FAIL busy_unexpected: got busy run %0d, expected none", busy_run);
            end else begin
                b = exp_busy.pop_front();
                if (b >= 0 && b != busy_run) begin
                    errors++;
                    $display("[TB] FAIL busy_len: got %0d cycles, expected %0d", busy_run, b);
                end
            end
            busy_run = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model of one fill: the block of the missing address, word by
    // word, with timing from the fixed-latency formula when it applies.
    task automatic push_fill(input logic [15:0] a, input int n, input bit timed, input int busy);
        logic [15:0] base;
        req_t        r;
        wr_t         w;
        base = a & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            r.addr = base + 16'(2 * k);
            r.cyc  = timed ? n + 1 + k : -1;
            exp_req.push_back(r);
            w.addr = r.addr;
            w.data = r.addr ^ 16'hA5A5;
            w.tag  = (k == 7);
            w.cyc  = timed ? n + 1 + lat + k : -1;
            exp_wr.push_back(w);
        end
        exp_busy.push_back(busy);
    endtask

    task automatic apply_stimulus(input logic [15:0] a, input bit timed, input int busy);
        push_fill(a, cyc, timed, busy);
        miss_detected = 1'b1;
        miss_address  = a;
        step(1);
        miss_detected = 1'b0;
        miss_address  = 16'($urandom);
    endtask

    task automatic wait_fill_done();
        int n;
        n = 0;
        while ((exp_req.size() != 0 || exp_wr.size() != 0) && n < 400) begin
            step(1);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("[TB] FAIL fill_timeout: got %0d writes outstanding, expected 0", exp_wr.size());
            exp_req.delete();
            exp_wr.delete();
        end
        step(1);
    endtask

    task automatic check_output(input string name);
        @(negedge clk);
        #2;
        checks++;
        if ({fsm_busy, mem_en, write_data_array, write_tag_array} !== 4'b0 ||
            memory_address !== 16'h0 || cache_addr !== 16'h0 || cache_data !== 16'h0) begin
            errors++;
            $display("[TB] FAIL %s: got busy %b en %b wd %b wt %b ma %h ca %h cd %h, expected all 0",
                     name, fsm_busy, mem_en, write_data_array, write_tag_array,
                     memory_address, cache_addr, cache_data);
        end
    endtask

    // Directed scenarios followed by randomized fills.
    initial begin
        int n;
        logic [15:0] a;
        rst           = 1'b1;
        miss_detected = 1'b0;
        miss_address  = 16'h0;
        step(1);
        check_output("reset_hold");
        step(1);
        rst = 1'b0;
        check_output("after_reset");
        step(1);

        // Basic fill with latency 4.
        lat      = 4;
        gap_mode = 1'b0;
        apply_stimulus(16'h1236, 1'b1, 13);
        wait_fill_done();

        // Miss held high and address changed during the fill: the block is
        // not re-latched, and the still-high miss in IDLE starts a new fill.
        n = cyc;
        push_fill(16'h1236, n, 1'b1, 13);
        miss_detected = 1'b1;
        miss_address  = 16'h1236;
        step(1);
        miss_address = 16'h4000;
        push_fill(16'h4000, n + 10 + lat, 1'b1, 13);
        step(10 + lat);
        miss_detected = 1'b0;
        wait_fill_done();

        // Random gaps between responses.
        lat      = 2;
        gap_mode = 1'b1;
        apply_stimulus(16'h5A5C, 1'b0, -1);
        wait_fill_done();
        gap_mode = 1'b0;

        // Top-of-memory block must not wrap.
        lat = 4;
        apply_stimulus(16'hFFFE, 1'b1, 13);
        wait_fill_done();

        // Reset three cycles into a fill, then a clean fill.
        apply_stimulus(16'h7778, 1'b1, 3);
        step(3);
        rst = 1'b1;
        exp_req.delete();
        exp_wr.delete();
        check_output("rst_midfill");
        step(1);
        rst = 1'b0;
        check_output("rst_then_idle");
        step(1);
        apply_stimulus(16'h0040, 1'b1, 13);
        wait_fill_done();

        // Stray valid pulses in IDLE and in the DONE cycle.
        spur_cyc.push_back(cyc);
        spur_cyc.push_back(cyc + 1);
        step(2);
        spur_cyc.push_back(cyc + 9 + lat);
        spur_cyc.push_back(cyc + 10 + lat);
        apply_stimulus(16'h2468, 1'b1, 13);
        wait_fill_done();
        step(2);
        spur_cyc.delete();

        // Randomized fills.
        for (int i = 0; i < 8; i++) begin
            lat      = $urandom_range(1, 6);
            gap_mode = ($urandom_range(0, 1) == 1);
            a        = 16'($urandom);
            apply_stimulus(a, !gap_mode, gap_mode ? -1 : 9 + lat);
            wait_fill_done();
        end

        step(4);
        checks++;
        if (exp_busy.size() != 0) begin
            errors++;
            $display("[TB] FAIL busy_leftover: got %0d pending busy runs, expected 0", exp_busy.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
